// File: rtl/fwrisc_exec_seq.sv
// fwrisc exec-stage sequencer: latches one decoded instruction, drives the ALU,
// runs shifts internally, then issues one register write and a completion pulse.
// Optional: FWRISC_EXEC_SEQ_FAST_SHIFT_EN selects a single-cycle barrel shifter.
//
// state | meaning
// IDLE  | ready for a new instruction; latches operands on decode_valid
// EXEC  | ALU sees latched operands; alu_out captured into result
// SHIFT | result shifted toward the final value (serial or barrel)
// WB    | one-cycle register-file write of result to rd
// DONE  | one-cycle instr_complete, illegal_op reports the illegal flag
module fwrisc_exec_seq #(
  parameter int REG_ADDR_W = 6,
  parameter int SHAMT_W    = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  decode_valid,
  output logic                  decode_ready,
  input  logic [4:0]            op_type,
  input  logic [5:0]            op,
  input  logic [31:0]           op_a,
  input  logic [31:0]           op_b,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic [31:0]           alu_op_a,
  output logic [31:0]           alu_op_b,
  output logic [5:0]            alu_op,
  input  logic [31:0]           alu_out,
  output logic [REG_ADDR_W-1:0] rd_waddr,
  output logic [31:0]           rd_wdata,
  output logic                  rd_wen,
  output logic                  instr_complete,
  output logic                  illegal_op
);

  localparam logic [4:0] OP_TYPE_ARITH = 5'd0;
  localparam logic [4:0] OP_TYPE_SHIFT = 5'd5;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;
  localparam logic [5:0] OP_AND = 6'd2;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_CLR = 6'd4;
  localparam logic [5:0] OP_EQ  = 6'd5;
  localparam logic [5:0] OP_LT  = 6'd7;
  localparam logic [5:0] OP_LTU = 6'd9;
  localparam logic [5:0] OP_OPA = 6'd11;
  localparam logic [5:0] OP_OPB = 6'd12;
  localparam logic [5:0] OP_XOR = 6'd13;
  localparam logic [5:0] OP_SLL = 6'd14;
  localparam logic [5:0] OP_SRL = 6'd15;
  localparam logic [5:0] OP_SRA = 6'd16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    SHIFT = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [5:0]            op_q;
  logic [31:0]           op_a_q, op_b_q, result_q, shift_nxt;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  illegal_q;
  logic                  accept, illegal_set, load_alu, shift_step;
  logic                  arith_ok, shift_ok;

  always_comb begin
    arith_ok = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CLR, OP_EQ,
      OP_LT, OP_LTU, OP_XOR, OP_OPA, OP_OPB: arith_ok = 1'b1;
      default: arith_ok = 1'b0;
    endcase
    shift_ok = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);
  end

`ifdef FWRISC_EXEC_SEQ_FAST_SHIFT_EN
  // result holds op_a on SHIFT entry, so one barrel pass yields the final value
  always_comb begin
    shift_nxt = result_q;
    case (op_q)
      OP_SLL:  shift_nxt = result_q << op_b_q[SHAMT_W-1:0];
      OP_SRL:  shift_nxt = result_q >> op_b_q[SHAMT_W-1:0];
      OP_SRA:  shift_nxt = $unsigned($signed(result_q) >>> op_b_q[SHAMT_W-1:0]);
      default: shift_nxt = result_q;
    endcase
  end
`else
  logic [SHAMT_W-1:0] shamt_q;

  always_comb begin
    shift_nxt = result_q;
    case (op_q)
      OP_SLL:  shift_nxt = {result_q[30:0], 1'b0};
      OP_SRL:  shift_nxt = {1'b0, result_q[31:1]};
      OP_SRA:  shift_nxt = {result_q[31], result_q[31:1]};
      default: shift_nxt = result_q;
    endcase
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    illegal_set    = 1'b0;
    load_alu       = 1'b0;
    shift_step     = 1'b0;
    decode_ready   = 1'b0;
    rd_wen         = 1'b0;
    rd_waddr       = '0;
    rd_wdata       = '0;
    instr_complete = 1'b0;
    illegal_op     = 1'b0;
    case (state)
      IDLE: begin
        decode_ready = !reset;
        if (decode_valid) begin
          accept = 1'b1;
          if (op_type == OP_TYPE_ARITH)      state_nxt = EXEC;
          else if (op_type == OP_TYPE_SHIFT) state_nxt = SHIFT;
          else begin
            illegal_set = 1'b1;
            state_nxt   = DONE;
          end
        end
      end
      EXEC: begin
        if (arith_ok) begin
          load_alu  = 1'b1;
          state_nxt = WB;
        end else begin
          illegal_set = 1'b1;
          state_nxt   = DONE;
        end
      end
      SHIFT: begin
        if (!shift_ok) begin
          illegal_set = 1'b1;
          state_nxt   = DONE;
        end else begin
`ifdef FWRISC_EXEC_SEQ_FAST_SHIFT_EN
          shift_step = 1'b1;
          state_nxt  = WB;
`else
          if (shamt_q == '0) state_nxt = WB;
          else               shift_step = 1'b1;
`endif
        end
      end
      WB: begin
        rd_wen    = 1'b1;
        rd_waddr  = rd_q;
        rd_wdata  = result_q;
        state_nxt = DONE;
      end
      DONE: begin
        instr_complete = 1'b1;
        illegal_op     = illegal_q;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= op;
        op_a_q    <= op_a;
        op_b_q    <= op_b;
        rd_q      <= rd;
        result_q  <= op_a;
        illegal_q <= 1'b0;
      end
      if (illegal_set) illegal_q <= 1'b1;
      if (load_alu)    result_q  <= alu_out;
      if (shift_step)  result_q  <= shift_nxt;
    end
  end

`ifndef FWRISC_EXEC_SEQ_FAST_SHIFT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)           shamt_q <= '0;
    else if (accept)     shamt_q <= op_b[SHAMT_W-1:0];
    else if (shift_step) shamt_q <= shamt_q - SHAMT_W'(1);
  end
`endif

  assign alu_op_a = op_a_q;
  assign alu_op_b = op_b_q;
  assign alu_op   = op_q;

endmodule

// File: tb/tb_fwrisc_exec_seq.sv
// Scoreboard bench for fwrisc_exec_seq: a driver pushes expected writes/completions
// with their due cycles, a negedge monitor pops and compares them.
module tb_fwrisc_exec_seq;

  localparam logic [4:0] T_ARITH = 5'd0, T_BRANCH = 5'd1, T_LDST = 5'd2, T_SHIFT = 5'd5;
  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, CLR = 6'd4,
                         EQ = 6'd5, NE = 6'd6, LT = 6'd7, GE = 6'd8, LTU = 6'd9,
                         GEU = 6'd10, OPA = 6'd11, OPB = 6'd12, XOR_ = 6'd13,
                         SLL = 6'd14, SRL = 6'd15, SRA = 6'd16;
`ifdef FWRISC_EXEC_SEQ_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clock = 1'b0, reset = 1'b1, decode_valid = 1'b0, decode_ready;
  logic [4:0]  op_type = '0;
  logic [5:0]  op = '0, rd = '0, alu_op, rd_waddr;
  logic [31:0] op_a = '0, op_b = '0, alu_op_a, alu_op_b, alu_out, rd_wdata;
  logic        rd_wen, instr_complete, illegal_op;

  fwrisc_exec_seq dut (
    .clock(clock), .reset(reset), .decode_valid(decode_valid), .decode_ready(decode_ready),
    .op_type(op_type), .op(op), .op_a(op_a), .op_b(op_b), .rd(rd),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op(alu_op), .alu_out(alu_out),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
    .instr_complete(instr_complete), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    bit          ill;
    int          at;
  } exp_t;
  exp_t expq[$];

  int checks = 0, failures = 0, free_cyc = 0;
  bit hold_valid = 1'b0;

  function automatic logic [31:0] alu_ref(logic [5:0] o, logic [31:0] a, logic [31:0] b);
    case (o)
      ADD:  return a + b;
      SUB:  return a - b;
      AND_: return a & b;
      OR_:  return a | b;
      CLR:  return b & ~a;
      EQ:   return {31'd0, a == b};
      LT:   return {31'd0, $signed(a) < $signed(b)};
      LTU:  return {31'd0, a < b};
      XOR_: return a ^ b;
      OPA:  return a;
      OPB:  return b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_out = alu_ref(alu_op, alu_op_a, alu_op_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      chk("wen_with_complete", 32'(rd_wen & instr_complete), 32'd0);
      if (!rd_wen) begin
        chk("waddr_when_idle", 32'(rd_waddr), 32'd0);
        chk("wdata_when_idle", rd_wdata, 32'd0);
      end
      if (!instr_complete) chk("illegal_without_complete", 32'(illegal_op), 32'd0);
      if (rd_wen) begin
        if (expq.size() == 0) chk("unexpected_wen", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("wen_kind", 32'(e.is_wr), 32'd1);
          chk("wen_cycle", 32'(cyc), 32'(e.at));
          chk("wen_addr", 32'(rd_waddr), 32'(e.addr));
          chk("wen_data", rd_wdata, e.data);
        end
      end
      if (instr_complete) begin
        if (expq.size() == 0) chk("unexpected_complete", 32'd1, 32'd0);
        else begin
          e = expq.pop_front();
          chk("complete_kind", 32'(e.is_wr), 32'd0);
          chk("complete_cycle", 32'(cyc), 32'(e.at));
          chk("complete_illegal", 32'(illegal_op), 32'(e.ill));
        end
      end
    end
  end

  // Called and returning on a negedge; 'abandon' means a reset will cut the instruction short.
  task automatic issue(input logic [4:0] t, input logic [5:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] r, input bit noisy,
                       input bit abandon);
    int waited, tacc, lw, lc, n;
    logic [31:0] res;
    bit legal;
    waited = 0;
    while (!decode_ready && waited < 100) begin
      chk("decode_ready_busy", 32'(decode_ready), 32'(cyc >= free_cyc));
      if (noisy) begin
        decode_valid = 1'b1;
        op_type = 5'($urandom);
        op = 6'($urandom);
        op_a = $urandom;
        op_b = $urandom;
        rd = 6'($urandom);
      end
      @(negedge clock);
      waited++;
    end
    if (!decode_ready) begin
      chk("decode_ready_timeout", 32'd0, 32'd1);
      return;
    end
    chk("decode_ready_accept", 32'(decode_ready), 32'(cyc >= free_cyc));
    decode_valid = 1'b1;
    op_type = t; op = o; op_a = a; op_b = b; rd = r;
    tacc = cyc;
    legal = 1'b0; lw = 0; res = '0;
    if (t == T_ARITH) begin
      legal = o inside {ADD, SUB, AND_, OR_, CLR, EQ, LT, LTU, XOR_, OPA, OPB};
      res = alu_ref(o, a, b);
      lw = 2;
      lc = legal ? 3 : 2;
    end else if (t == T_SHIFT) begin
      legal = o inside {SLL, SRL, SRA};
      n = int'(b[4:0]);
      res = (o == SLL) ? a << n : (o == SRL) ? a >> n : $unsigned($signed(a) >>> n);
      lw = FAST ? 2 : n + 2;
      lc = legal ? lw + 1 : 2;
    end else begin
      lc = 1;
    end
    if (!abandon) begin
      if (legal) expq.push_back('{1'b1, r, res, 1'b0, tacc + lw});
      expq.push_back('{1'b0, 6'd0, 32'd0, !legal, tacc + lc});
    end
    free_cyc = tacc + lc + 1;
    @(negedge clock);
    if (!hold_valid) decode_valid = 1'b0;
  endtask

  logic [5:0] arith_ops [11] = '{ADD, SUB, AND_, OR_, CLR, EQ, LT, LTU, XOR_, OPA, OPB};
  logic [5:0] shift_ops [3]  = '{SLL, SRL, SRA};

  initial begin
    int sel, tmo;
    logic [4:0] t;
    logic [5:0] o;
    repeat (3) @(negedge clock);
    chk("reset_ready_low", 32'(decode_ready), 32'd0);
    chk("reset_wen", 32'(rd_wen), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    free_cyc = cyc;
    chk("reset_alu_op_a", alu_op_a, 32'd0);

    issue(T_ARITH, ADD, 32'h0000_0005, 32'hFFFF_FFFE, 6'd3, 1'b0, 1'b0);
    issue(T_ARITH, LT,  32'h8000_0000, 32'h1, 6'd4, 1'b0, 1'b0);
    issue(T_ARITH, LTU, 32'h8000_0000, 32'h1, 6'd5, 1'b0, 1'b0);
    issue(T_ARITH, CLR, 32'h0F, 32'hFF, 6'd6, 1'b0, 1'b0);
    issue(T_SHIFT, SRA, 32'h8000_0010, 32'd4, 6'd7, 1'b0, 1'b0);
    issue(T_SHIFT, SLL, 32'h1234_5678, 32'd0, 6'd8, 1'b0, 1'b0);
    issue(T_SHIFT, SRL, 32'h8000_0001, 32'd31, 6'd9, 1'b0, 1'b0);
    issue(T_ARITH, NE,  32'h1, 32'h2, 6'd10, 1'b0, 1'b0);
    issue(T_LDST,  ADD, 32'h1, 32'h2, 6'd11, 1'b0, 1'b0);
    issue(T_ARITH, ADD, 32'h1, 32'h2, 6'd0, 1'b0, 1'b0);
    hold_valid = 1'b1;
    issue(T_ARITH, ADD, 32'd10, 32'd20, 6'd12, 1'b0, 1'b0);
    issue(T_ARITH, ADD, 32'd7, 32'd8, 6'd13, 1'b0, 1'b0);
    hold_valid = 1'b0;
    decode_valid = 1'b0;

    // reset lands five cycles after accept, mid-shift in the serial build
    issue(T_SHIFT, SRA, 32'h8000_0010, 32'd20, 6'd14, 1'b0, !FAST);
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_decode_ready", 32'(decode_ready), 32'd0);
    chk("rst_wen", 32'(rd_wen), 32'd0);
    chk("rst_complete", 32'(instr_complete), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_wdata", rd_wdata, 32'd0);
    chk("rst_alu_op_a", alu_op_a, 32'd0);
    chk("rst_alu_op_b", alu_op_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    free_cyc = cyc;
    @(posedge clock);
    @(negedge clock);
    chk("ready_after_reset", 32'(decode_ready), 32'd1);
    free_cyc = cyc;

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        t = T_ARITH;
        o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : arith_ops[$urandom_range(0, 10)];
      end else if (sel <= 8) begin
        t = T_SHIFT;
        o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : shift_ops[$urandom_range(0, 2)];
      end else begin
        t = 5'($urandom_range(1, 31));
        if (t == T_SHIFT) t = T_BRANCH;
        o = 6'($urandom);
      end
      hold_valid = ($urandom_range(0, 3) == 0);
      issue(t, o, $urandom, $urandom, 6'($urandom), 1'($urandom), 1'b0);
    end
    hold_valid = 1'b0;
    decode_valid = 1'b0;

    tmo = 0;
    while ((cyc <= free_cyc + 1) && tmo < 200) begin
      @(negedge clock);
      tmo++;
    end
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwrisc_exec_seq.md
Name: fwrisc_exec_seq

Overview:
- Exec-stage sequencer for fwrisc. Accepts one decoded instruction at a time and drives the shared ALU with latched operands.
- Runs multi-cycle shifts with an internal shifter, then issues exactly one register-file write followed by an instr_complete pulse.
- Sits between decode and the register file/ALU. Its write/complete ordering is the one the exec formal checkers check.

Parameters:
REG_ADDR_W, 6, width of rd / rd_waddr.
SHAMT_W, 5, width of shift amount taken from op_b[SHAMT_W-1:0].

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-high reset
decode_valid  in  1  decoded instruction available
decode_ready  out  1  sequencer can accept (IDLE only)
op_type  in  5  OP_TYPE_* from fwrisc_op_type.svh
op  in  6  OP_* from fwrisc_alu_op.svh
op_a  in  32  operand A
op_b  in  32  operand B / shift amount
rd  in  REG_ADDR_W  destination register
alu_op_a  out  32  latched operand A to ALU
alu_op_b  out  32  latched operand B to ALU
alu_op  out  6  latched ALU op
alu_out  in  32  combinational ALU result
rd_waddr  out  REG_ADDR_W  write address
rd_wdata  out  32  write data
rd_wen  out  1  write strobe, one cycle
instr_complete  out  1  completion pulse, one cycle
illegal_op  out  1  pulse with instr_complete for unsupported op_type/op

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE immediately.
  - All outputs 0, except decode_ready, which is 1 after reset deasserts.
  - Latched operands and shift counter are cleared.
  - A reset mid-instruction abandons it: no rd_wen, no instr_complete.
- States: IDLE, EXEC, SHIFT, WB, DONE.
- IDLE:
  - decode_ready=1.
  - When decode_valid=1, latch op_type, op, op_a, op_b, rd.
  - Next state is EXEC for OP_TYPE_ARITH, SHIFT for OP_TYPE_SHIFT, DONE with illegal flag set for anything else.
- EXEC:
  - alu_op_a/alu_op_b/alu_op present the latched values.
  - Register alu_out into the result register; next state WB.
  - ARITH ops accepted: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_CLR, OP_EQ, OP_LT, OP_LTU, OP_XOR, OP_OPA, OP_OPB. Any other op sets the illegal flag and goes to DONE.
- SHIFT:
  - On entry, the result register = op_a and the counter = op_b[SHAMT_W-1:0].
  - Each cycle with counter≠0: shift the result 1 bit and decrement the counter.
    - OP_SLL: left, zero fill.
    - OP_SRL: right, zero fill.
    - OP_SRA: right, sign fill.
  - Counter==0 (including an amount of 0 on entry) → WB.
  - Any other op → DONE with illegal flag set.
  - Amounts ≥32 cannot occur (SHAMT_W=5). Shift latency = amount+1 cycles in SHIFT.
- WB:
  - rd_wen=1, rd_waddr=rd, rd_wdata=result for exactly one cycle; next state DONE.
  - rd=0 still writes; the register file discards it.
- DONE:
  - instr_complete=1 for one cycle; illegal_op=illegal flag.
  - Next state IDLE.
  - rd_wen and instr_complete are never asserted in the same cycle.
- Latency, acceptance at cycle T:
  - ARITH: rd_wen at T+2, instr_complete at T+3, decode_ready again at T+4.
  - SHIFT by n: rd_wen at T+n+2, instr_complete at T+n+3.
  - Illegal: instr_complete+illegal_op at T+1, no rd_wen.
- decode_valid outside IDLE is ignored (not latched); decode must hold it until accepted.
- rd_waddr and rd_wdata are 0 whenever rd_wen=0.
- Back-to-back instructions: a new accept can occur the cycle after DONE. There is exactly one rd_wen per legal instruction.

Optional Feature:
- Macro: FWRISC_EXEC_SEQ_FAST_SHIFT_EN.
- Defined:
  - SHIFT performs the full barrel shift in a single cycle regardless of amount, then goes to WB.
  - Shift latency matches ARITH: rd_wen at T+2, instr_complete at T+3.
  - The counter is not built.
- Undefined: 1 bit/cycle serial shift as described above.
- Write/complete ordering is identical either way.

Test Plan:
- ARITH OP_ADD, op_a=0x0000_0005, op_b=0xFFFF_FFFE, rd=3, accepted at T → rd_wen at T+2 with rd_waddr=3, rd_wdata=0x0000_0003; instr_complete at T+3; decode_ready low T+1..T+3.
- ARITH OP_LT, op_a=0x8000_0000, op_b=1 → rd_wdata=1. OP_LTU with the same operands → rd_wdata=0. OP_CLR, op_a=0x0F, op_b=0xFF → rd_wdata=0xF0.
- SHIFT OP_SRA, op_a=0x8000_0010, op_b=4:
  - Serial: rd_wen at T+6, rd_wdata=0xF800_0001.
  - FAST_SHIFT_EN: rd_wen at T+2, same data.
  - Amount 0: rd_wdata=op_a, rd_wen at T+2.
- Illegal op_type (e.g. OP_TYPE_LDST) accepted → instr_complete and illegal_op at T+1, no rd_wen; decode_ready high at T+2.
- Reset asserted asynchronously mid-SHIFT (amount 20, cycle T+5) → outputs 0 immediately; no rd_wen or instr_complete; decode_ready=1 on the first clock after deassertion.
- Two back-to-back ADDs with decode_valid held high → exactly two rd_wen and two instr_complete pulses, rd_wen always one cycle before instr_complete, second accept the cycle after the first DONE.
